pipe_hazard_ctrl: RTL and testbench

- Hazard and stall sequencer for the 5-stage pipelined MIPS core (IF/ID/EX/MEM/WB).
- Generates pipeline-register enables and flushes for:
  - load-use interlocks
  - taken branches (resolved in EX) and jumps (decoded in ID)
  - multi-cycle data-memory waits
- Also generates the EX-stage operand forwarding selects and keeps a stall-cycle counter and a memory-timeout error flag.
- Sits beside the main decoder; consumes its decoded control bits per stage.

---
 rtl/pipe_hazard_ctrl.sv | 174 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and stall sequencer for the 5-stage MIPS pipeline.
//
// Purpose: drives the pipeline-register enables/flushes for load-use
// interlocks, taken branches (resolved in EX), jumps (decoded in ID) and
// multi-cycle data-memory waits. It also produces the EX-stage forwarding
// selects, a saturating stall-cycle counter and a sticky memory-timeout flag.
//
// Ports:
//   clk, rst_n               clock (rising edge), async active-low reset
//   id_rs, id_rt, id_uses_rt ID-stage source fields and rt-read flag
//   id_jmp                   ID instruction is j
//   ex_rs, ex_rt             EX-stage source fields (ex_rt = lw destination)
//   ex_mem_read              EX instruction is lw
//   ex_branch_taken          EX beq/bne resolved taken
//   mem_regwrite, mem_dst    MEM-stage writeback info
//   wb_regwrite, wb_dst      WB-stage writeback info
//   mem_req, mem_ready       data-memory handshake in MEM
//   pc_en, ifid_en, idex_en, exmem_en   pipeline enables
//   ifid_flush, idex_flush   load NOP / bubble into IF/ID, ID/EX
//   fwd_a, fwd_b             operand selects: 00 regfile, 10 MEM, 01 WB
//   mem_err                  sticky memory-timeout flag
//   stall_cycles             saturating count of cycles with pc_en=0
module pipe_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_jmp,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             mem_regwrite,
    input  logic [4:0]       mem_dst,
    input  logic             wb_regwrite,
    input  logic [4:0]       wb_dst,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t            state, state_next;
    logic [WAIT_W-1:0] wait_cnt, wait_next;
    logic              err_set;
    logic              run_eval;
    logic              load_use;
    logic              mem_stall;

    // Forwarding: $0 is never a source; MEM result beats WB result.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (rst_n) begin
            if (mem_regwrite && mem_dst != 5'd0 && mem_dst == ex_rs)
                fwd_a = 2'b10;
            else if (wb_regwrite && wb_dst != 5'd0 && wb_dst == ex_rs)
                fwd_a = 2'b01;
            if (mem_regwrite && mem_dst != 5'd0 && mem_dst == ex_rt)
                fwd_b = 2'b10;
            else if (wb_regwrite && wb_dst != 5'd0 && wb_dst == ex_rt)
                fwd_b = 2'b01;
        end
    end

    assign load_use  = ex_mem_read && ex_rt != 5'd0 &&
                       (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
    assign mem_stall = mem_req && !mem_ready;

    always_comb begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b0;
        idex_en    = 1'b0;
        idex_flush = 1'b0;
        exmem_en   = 1'b0;
        state_next = state;
        wait_next  = wait_cnt;
        run_eval   = 1'b0;
        err_set    = 1'b0;

        if (!rst_n) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (mem_stall) begin
                        state_next = MEM_WAIT;
                        wait_next  = WAIT_W'(1);
                    end else begin
                        run_eval = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        state_next = RUN;
                        wait_next  = '0;
                        run_eval   = 1'b1;
                    end else if (wait_cnt != WAIT_MAX) begin
                        wait_next = wait_cnt + WAIT_W'(1);
                    end
                end
                default: state_next = RUN;
            endcase

            // Timeout is flagged on the edge where the count arrives at the
            // limit, so mem_err and the saturated count appear together.
            err_set = (state_next == MEM_WAIT) && (wait_next == WAIT_MAX);

            // A taken branch squashes the ID instruction, so a load-use or
            // jump seen there at the same time is irrelevant.
            if (run_eval) begin
                if (ex_branch_taken) begin
                    pc_en      = 1'b1;
                    ifid_en    = 1'b1;
                    ifid_flush = 1'b1;
                    idex_en    = 1'b1;
                    idex_flush = 1'b1;
                    exmem_en   = 1'b1;
                end else if (load_use) begin
                    idex_en    = 1'b1;
                    idex_flush = 1'b1;
                    exmem_en   = 1'b1;
                end else if (id_jmp) begin
                    pc_en      = 1'b1;
                    ifid_en    = 1'b1;
                    ifid_flush = 1'b1;
                    idex_en    = 1'b1;
                    exmem_en   = 1'b1;
                end else begin
                    pc_en    = 1'b1;
                    ifid_en  = 1'b1;
                    idex_en  = 1'b1;
                    exmem_en = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RUN;
            wait_cnt     <= '0;
            mem_err      <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
            if (err_set)
                mem_err <= 1'b1;
            if (!pc_en && stall_cycles != '1)
                stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scenarios plus randomized traffic checked
// against an event-priority reference model of the hazard controller.
module tb_pipe_hazard_ctrl;

    localparam int unsigned TO = 4;
    localparam int unsigned CW = 5;
    localparam int SAT = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic [4:0]    id_rs, id_rt, ex_rs, ex_rt, mem_dst, wb_dst;
    logic          id_uses_rt, id_jmp, ex_mem_read, ex_branch_taken;
    logic          mem_regwrite, wb_regwrite, mem_req, mem_ready;
    logic          pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en;
    logic [1:0]    fwd_a, fwd_b;
    logic          mem_err;
    logic [CW-1:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_wait;
    int m_wcnt;
    bit m_err;
    int m_stalls;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_jmp(id_jmp),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken),
        .mem_regwrite(mem_regwrite), .mem_dst(mem_dst),
        .wb_regwrite(wb_regwrite), .wb_dst(wb_dst),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_err(mem_err),
        .stall_cycles(stall_cycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en}
    function automatic logic [5:0] ctl();
        return {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en};
    endfunction

    task automatic set_idle();
        id_rs = 0; id_rt = 0; id_uses_rt = 0; id_jmp = 0;
        ex_rs = 0; ex_rt = 0; ex_mem_read = 0; ex_branch_taken = 0;
        mem_regwrite = 0; mem_dst = 0; wb_regwrite = 0; wb_dst = 0;
        mem_req = 0; mem_ready = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        set_idle();
        @(negedge clk);
        rst_n = 1'b1;
        m_wait = 0; m_wcnt = 0; m_err = 0; m_stalls = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        mem_regwrite = 1; mem_dst = 5; ex_rs = 5; ex_rt = 5; mem_req = 1;
        #2;
        checks++;
        if (ctl() !== 6'b001010) begin
            errors++; $display("FAIL reset_ctl got %b want 001010", ctl());
        end
        checks++;
        if ({fwd_a, fwd_b} !== 4'b0000) begin
            errors++; $display("FAIL reset_fwd got %b want 0000", {fwd_a, fwd_b});
        end
        checks++;
        if (mem_err !== 1'b0 || stall_cycles !== '0) begin
            errors++; $display("FAIL reset_regs got err=%b stall=%0d want 0/0", mem_err, stall_cycles);
        end
        do_reset();
    endtask

    task automatic test_forwarding();
        @(negedge clk);
        set_idle();
        mem_regwrite = 1; mem_dst = 5; wb_regwrite = 1; wb_dst = 5; ex_rs = 5; ex_rt = 0;
        #1;
        checks++;
        if (fwd_a !== 2'b10 || fwd_b !== 2'b00) begin
            errors++; $display("FAIL fwd_mem got a=%b b=%b want 10/00", fwd_a, fwd_b);
        end
        mem_regwrite = 0;
        #1;
        checks++;
        if (fwd_a !== 2'b01) begin
            errors++; $display("FAIL fwd_wb got %b want 01", fwd_a);
        end
        mem_regwrite = 1; mem_dst = 0; wb_dst = 0; ex_rs = 0;
        #1;
        checks++;
        if (fwd_a !== 2'b00) begin
            errors++; $display("FAIL fwd_r0 got %b want 00", fwd_a);
        end
        mem_dst = 7; wb_dst = 9; ex_rs = 3; ex_rt = 9;
        #1;
        checks++;
        if (fwd_a !== 2'b00 || fwd_b !== 2'b01) begin
            errors++; $display("FAIL fwd_b_wb got a=%b b=%b want 00/01", fwd_a, fwd_b);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        ex_mem_read = 1; ex_rt = 8; id_rs = 8;
        #1;
        checks++;
        if (ctl() !== 6'b000111) begin
            errors++; $display("FAIL lu_stall got %b want 000111", ctl());
        end
        @(posedge clk); #1;
        checks++;
        if (stall_cycles !== CW'(1)) begin
            errors++; $display("FAIL lu_count got %0d want 1", stall_cycles);
        end
        @(negedge clk);
        ex_mem_read = 0; ex_rt = 0;
        #1;
        checks++;
        if (ctl() !== 6'b110101) begin
            errors++; $display("FAIL lu_resume got %b want 110101", ctl());
        end
        ex_mem_read = 1; ex_rt = 8; id_rs = 9; id_rt = 8; id_uses_rt = 0;
        #1;
        checks++;
        if (ctl() !== 6'b110101) begin
            errors++; $display("FAIL lu_no_rt got %b want 110101", ctl());
        end
        id_uses_rt = 1;
        #1;
        checks++;
        if (pc_en !== 1'b0) begin
            errors++; $display("FAIL lu_rt got pc_en=%b want 0", pc_en);
        end
        ex_rt = 0; id_rs = 0; id_rt = 0;
        #1;
        checks++;
        if (pc_en !== 1'b1) begin
            errors++; $display("FAIL lu_r0 got pc_en=%b want 1", pc_en);
        end
        @(posedge clk); #1;
        checks++;
        if (stall_cycles !== CW'(1)) begin
            errors++; $display("FAIL lu_count2 got %0d want 1", stall_cycles);
        end
    endtask

    task automatic test_branch_priority();
        do_reset();
        ex_branch_taken = 1; ex_mem_read = 1; ex_rt = 4; id_rs = 4; id_jmp = 1;
        #1;
        checks++;
        if (ctl() !== 6'b111111) begin
            errors++; $display("FAIL br_prio got %b want 111111", ctl());
        end
        @(posedge clk); #1;
        checks++;
        if (stall_cycles !== '0) begin
            errors++; $display("FAIL br_count got %0d want 0", stall_cycles);
        end
    endtask

    task automatic test_jump();
        do_reset();
        id_jmp = 1;
        #1;
        checks++;
        if (ctl() !== 6'b111101) begin
            errors++; $display("FAIL jump got %b want 111101", ctl());
        end
    endtask

    task automatic test_mem_wait();
        do_reset();
        mem_req = 1; mem_ready = 0; ex_branch_taken = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (ctl() !== 6'b000000) begin
                errors++; $display("FAIL mw_hold%0d got %b want 000000", i, ctl());
            end
            @(negedge clk);
        end
        ex_branch_taken = 0; mem_ready = 1; id_jmp = 1;
        #1;
        checks++;
        if (ctl() !== 6'b111101) begin
            errors++; $display("FAIL mw_done got %b want 111101", ctl());
        end
        @(posedge clk); #1;
        checks++;
        if (stall_cycles !== CW'(3) || mem_err !== 1'b0) begin
            errors++; $display("FAIL mw_count got stall=%0d err=%b want 3/0", stall_cycles, mem_err);
        end
        @(negedge clk);
        set_idle();
        #1;
        checks++;
        if (ctl() !== 6'b110101) begin
            errors++; $display("FAIL mw_run got %b want 110101", ctl());
        end
    endtask

    task automatic test_timeout();
        do_reset();
        mem_req = 1; mem_ready = 0;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk); #1;
            checks++;
            if (mem_err !== (i >= int'(TO))) begin
                errors++; $display("FAIL to_err%0d got %b want %b", i, mem_err, i >= int'(TO));
            end
        end
        @(negedge clk);
        mem_ready = 1;
        #1;
        checks++;
        if (pc_en !== 1'b1) begin
            errors++; $display("FAIL to_release got pc_en=%b want 1", pc_en);
        end
        @(posedge clk); #1;
        checks++;
        if (mem_err !== 1'b1) begin
            errors++; $display("FAIL to_sticky got %b want 1", mem_err);
        end
        @(negedge clk);
        mem_ready = 0;
        @(posedge clk); @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_err !== 1'b0 || stall_cycles !== '0 || pc_en !== 1'b0) begin
            errors++; $display("FAIL to_async got err=%b stall=%0d pc=%b want 0/0/0", mem_err, stall_cycles, pc_en);
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_idle();
        #1;
        checks++;
        if (ctl() !== 6'b110101) begin
            errors++; $display("FAIL to_run got %b want 110101", ctl());
        end
        mem_req = 1;
        for (int i = 0; i < int'(TO) - 1; i++) @(posedge clk);
        #1;
        checks++;
        if (mem_err !== 1'b0) begin
            errors++; $display("FAIL to_cleared got %b want 0", mem_err);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < SAT + 10; i++) @(posedge clk);
        #1;
        checks++;
        if (stall_cycles !== CW'(SAT)) begin
            errors++; $display("FAIL sat got %0d want %0d", stall_cycles, SAT);
        end
    endtask

    // Reference: forwarding source for one EX operand register.
    function automatic logic [1:0] ref_fwd(input logic [4:0] r);
        if (mem_regwrite && mem_dst != 0 && mem_dst == r) return 2'b10;
        if (wb_regwrite && wb_dst != 0 && wb_dst == r) return 2'b01;
        return 2'b00;
    endfunction

    // Reference: control vector from the event priority list.
    function automatic logic [5:0] ref_ctl();
        bit held;
        bit lu;
        held = m_wait ? !mem_ready : (mem_req && !mem_ready);
        lu = ex_mem_read && ex_rt != 0 &&
             (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
        if (held)            return 6'b000000;
        if (ex_branch_taken) return 6'b111111;
        if (lu)              return 6'b000111;
        if (id_jmp)          return 6'b111101;
        return 6'b110101;
    endfunction

    task automatic test_random();
        logic [5:0] exp_ctl;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            id_rs = 5'($urandom_range(0, 3));
            id_rt = 5'($urandom_range(0, 3));
            ex_rs = 5'($urandom_range(0, 3));
            ex_rt = 5'($urandom_range(0, 3));
            mem_dst = 5'($urandom_range(0, 3));
            wb_dst = 5'($urandom_range(0, 3));
            id_uses_rt = 1'($urandom);
            id_jmp = ($urandom_range(0, 3) == 0);
            ex_mem_read = 1'($urandom);
            ex_branch_taken = ($urandom_range(0, 4) == 0);
            mem_regwrite = 1'($urandom);
            wb_regwrite = 1'($urandom);
            mem_req = ($urandom_range(0, 3) == 0);
            mem_ready = ($urandom_range(0, 2) != 0);
            #1;
            exp_ctl = ref_ctl();
            checks++;
            if (ctl() !== exp_ctl || fwd_a !== ref_fwd(ex_rs) || fwd_b !== ref_fwd(ex_rt)) begin
                errors++;
                $display("FAIL rnd_comb%0d got ctl=%b a=%b b=%b want ctl=%b a=%b b=%b",
                         n, ctl(), fwd_a, fwd_b, exp_ctl, ref_fwd(ex_rs), ref_fwd(ex_rt));
            end
            @(posedge clk);
            if (exp_ctl[5] == 1'b0 && m_stalls < SAT) m_stalls++;
            if (!m_wait) begin
                if (mem_req && !mem_ready) begin m_wait = 1; m_wcnt = 1; end
            end else if (mem_ready) begin
                m_wait = 0; m_wcnt = 0;
            end else if (m_wcnt < int'(TO)) begin
                m_wcnt++;
            end
            if (m_wait && m_wcnt >= int'(TO)) m_err = 1;
            #1;
            checks++;
            if (stall_cycles !== CW'(m_stalls) || mem_err !== m_err) begin
                errors++;
                $display("FAIL rnd_regs%0d got stall=%0d err=%b want stall=%0d err=%b",
                         n, stall_cycles, mem_err, m_stalls, m_err);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        set_idle();
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch_priority();
        test_jump();
        test_mem_wait();
        test_timeout();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
